// File: rtl/mod6_down_counter_if.sv
// mod6_down_counter_if
//   Control/status bundle of one mod-MOD down-counter stage.
//   master : drives LC, I, EN, BI; observes Q, BO, ZERO, ERR, WCNT
//   slave  : the counter stage itself (opposite directions)
//   LC   load control (1 = load I, 0 = count)
//   I    parallel load value, W bits
//   EN   local count enable
//   BI   borrow-in from the less-significant stage (tie 1 on the LS stage)
//   Q    registered count, W bits
//   BO   borrow-out to the next stage, combinational
//   ZERO Q == 0, combinational
//   ERR  sticky illegal-load flag
//   WCNT saturating count of 0 -> MOD-1 wraps, WCW bits
interface mod6_down_counter_if #(
   parameter int W   = 3,
   parameter int WCW = 8
);
   logic           LC;
   logic [W-1:0]   I;
   logic           EN;
   logic           BI;
   logic [W-1:0]   Q;
   logic           BO;
   logic           ZERO;
   logic           ERR;
   logic [WCW-1:0] WCNT;

   modport master (
      output LC, I, EN, BI,
      input  Q, BO, ZERO, ERR, WCNT
   );

   modport slave (
      input  LC, I, EN, BI,
      output Q, BO, ZERO, ERR, WCNT
   );
endinterface

// File: rtl/mod6_down_counter.sv
// mod6_down_counter
//   Loadable modulo-MOD down counter (default 5,4,3,2,1,0,5,...) with
//   borrow-in/borrow-out for cascading, sticky illegal-load flag and a
//   saturating wrap-event counter.
//   CLK  rising-edge clock
//   CLR  asynchronous clear, active-low (Q, ERR, WCNT -> 0)
//   bus  slave side of mod6_down_counter_if (LC, I, EN, BI in;
//        Q, BO, ZERO, ERR, WCNT out)
//   Priority at the clock edge: load > count (EN & BI) > hold.
module mod6_down_counter #(
   parameter int MOD = 6,
   parameter int W   = 3,
   parameter int WCW = 8
) (
   input  logic                  CLK,
   input  logic                  CLR,
   mod6_down_counter_if.slave    bus
);

   localparam logic [W-1:0] QMAX = W'(MOD - 1);

   logic [W-1:0]   q;
   logic           err;
   logic [WCW-1:0] wcnt;
   logic           cnt_en;

   assign cnt_en = bus.EN & bus.BI;

   always_ff @(posedge CLK or negedge CLR) begin
      if (!CLR) begin
         q    <= '0;
         err  <= 1'b0;
         wcnt <= '0;
      end else if (bus.LC) begin
         // Out-of-range loads clamp to the top legal value and raise ERR.
         if (bus.I <= QMAX) begin
            q   <= bus.I;
            err <= 1'b0;
         end else begin
            q   <= QMAX;
            err <= 1'b1;
         end
      end else if (cnt_en) begin
         if (q == '0) begin
            q <= QMAX;
            if (wcnt != '1)
               wcnt <= wcnt + WCW'(1);
         end else if (q > QMAX) begin
            // Unreachable in normal operation; recovers without a wrap event.
            q <= QMAX;
         end else begin
            q <= q - W'(1);
         end
      end
   end

   assign bus.Q    = q;
   assign bus.ERR  = err;
   assign bus.WCNT = wcnt;
   assign bus.ZERO = (q == '0);
   // High during the cycle whose edge performs the wrap.
   assign bus.BO   = ~bus.LC & cnt_en & (q == '0);

endmodule

// File: tb/tb_mod6_down_counter.sv
module tb_mod6_down_counter;
   localparam int MOD = 6;

   logic CLK = 1'b0;
   logic CLR = 1'b0;

   always #5 CLK = ~CLK;

   // Stage 0 -> stage 1 cascade, plus an independent stage with a 2-bit WCNT.
   mod6_down_counter_if #(.W(3), .WCW(8)) bus0 ();
   mod6_down_counter_if #(.W(3), .WCW(8)) bus1 ();
   mod6_down_counter_if #(.W(3), .WCW(2)) bus2 ();

   assign bus1.BI = bus0.BO;

   mod6_down_counter #(.MOD(MOD), .W(3), .WCW(8)) u0 (.CLK(CLK), .CLR(CLR), .bus(bus0));
   mod6_down_counter #(.MOD(MOD), .W(3), .WCW(8)) u1 (.CLK(CLK), .CLR(CLR), .bus(bus1));
   mod6_down_counter #(.MOD(MOD), .W(3), .WCW(2)) u2 (.CLK(CLK), .CLR(CLR), .bus(bus2));

   int checks = 0;
   int errors = 0;

   // Reference model: plain integers per stage.
   int mq[3];
   int merr[3];
   int mw[3];
   int wmax[3] = '{255, 255, 3};

   // Stimulus per stage (bi[1] is unused: stage 1 borrows from stage 0).
   bit lc[3];
   int iv[3];
   bit en[3];
   bit bi[3];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic apply();
      bus0.LC = lc[0]; bus0.I = 3'(iv[0]); bus0.EN = en[0]; bus0.BI = bi[0];
      bus1.LC = lc[1]; bus1.I = 3'(iv[1]); bus1.EN = en[1];
      bus2.LC = lc[2]; bus2.I = 3'(iv[2]); bus2.EN = en[2]; bus2.BI = bi[2];
   endtask

   task automatic set_all(input bit l, input int v, input bit e, input bit b);
      for (int k = 0; k < 3; k++) begin
         lc[k] = l; iv[k] = v; en[k] = e; bi[k] = b;
      end
      apply();
   endtask

   task automatic mstep(input int k, input bit l, input int v, input bit e, input bit b);
      if (l) begin
         if (v < MOD) begin mq[k] = v; merr[k] = 0; end
         else begin mq[k] = MOD - 1; merr[k] = 1; end
      end else if (e && b) begin
         if (mq[k] == 0 && mw[k] < wmax[k]) mw[k]++;
         mq[k] = (mq[k] + MOD - 1) % MOD;
      end
   endtask

   task automatic mclear();
      for (int k = 0; k < 3; k++) begin mq[k] = 0; merr[k] = 0; mw[k] = 0; end
   endtask

   // One clock: combinational checks at negedge, state checks 1 time unit after posedge.
   task automatic step();
      bit b0, b1, b2;
      @(negedge CLK);
      b0 = !lc[0] && en[0] && bi[0] && (mq[0] == 0);
      b1 = !lc[1] && en[1] && b0 && (mq[1] == 0);
      b2 = !lc[2] && en[2] && bi[2] && (mq[2] == 0);
      chk("bo0", 32'(bus0.BO), 32'(b0));
      chk("bo1", 32'(bus1.BO), 32'(b1));
      chk("bo2", 32'(bus2.BO), 32'(b2));
      chk("zero0", 32'(bus0.ZERO), 32'(mq[0] == 0));
      chk("zero1", 32'(bus1.ZERO), 32'(mq[1] == 0));
      chk("zero2", 32'(bus2.ZERO), 32'(mq[2] == 0));
      mstep(0, lc[0], iv[0], en[0], bi[0]);
      mstep(1, lc[1], iv[1], en[1], b0);
      mstep(2, lc[2], iv[2], en[2], bi[2]);
      @(posedge CLK);
      #1;
      chk("q0", 32'(bus0.Q), 32'(mq[0]));
      chk("q1", 32'(bus1.Q), 32'(mq[1]));
      chk("q2", 32'(bus2.Q), 32'(mq[2]));
      chk("err0", 32'(bus0.ERR), 32'(merr[0]));
      chk("err1", 32'(bus1.ERR), 32'(merr[1]));
      chk("err2", 32'(bus2.ERR), 32'(merr[2]));
      chk("wcnt0", 32'(bus0.WCNT), 32'(mw[0]));
      chk("wcnt1", 32'(bus1.WCNT), 32'(mw[1]));
      chk("wcnt2", 32'(bus2.WCNT), 32'(mw[2]));
   endtask

   // Asynchronous clear issued between edges, checked before the next edge.
   task automatic do_clear();
      CLR = 1'b0;
      #1;
      mclear();
      chk("clr_q0", 32'(bus0.Q), 0);
      chk("clr_err0", 32'(bus0.ERR), 0);
      chk("clr_wcnt0", 32'(bus0.WCNT), 0);
      chk("clr_q2", 32'(bus2.Q), 0);
      chk("clr_wcnt2", 32'(bus2.WCNT), 0);
      #2;
      CLR = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seq[7] = '{3, 2, 1, 0, 5, 4, 3};

      set_all(1'b0, 0, 1'b0, 1'b0);
      mclear();
      #3;
      chk("reset_q0", 32'(bus0.Q), 0);
      chk("reset_err0", 32'(bus0.ERR), 0);
      chk("reset_wcnt0", 32'(bus0.WCNT), 0);
      chk("reset_zero0", 32'(bus0.ZERO), 1);
      @(posedge CLK);
      #1;
      CLR = 1'b1;

      // Randomized traffic on all stages.
      for (int n = 0; n < 300; n++) begin
         for (int k = 0; k < 3; k++) begin
            lc[k] = ($urandom_range(0, 7) == 0);
            iv[k] = $urandom_range(0, 7);
            en[k] = ($urandom_range(0, 3) != 0);
            bi[k] = ($urandom_range(0, 3) != 0);
         end
         apply();
         step();
      end

      // Clear mid-count with Q=3, ERR=1, WCNT=4 on stage 0.
      do_clear();
      set_all(1'b1, 7, 1'b0, 1'b0);
      step();
      set_all(1'b0, 0, 1'b1, 1'b1);
      for (int n = 0; n < 26; n++) step();
      chk("pre_clr_q", 32'(bus0.Q), 3);
      chk("pre_clr_err", 32'(bus0.ERR), 1);
      chk("pre_clr_wcnt", 32'(bus0.WCNT), 4);
      do_clear();

      // Load 4, count 7 edges.
      set_all(1'b1, 4, 1'b1, 1'b1);
      step();
      chk("load4_q", 32'(bus0.Q), 4);
      set_all(1'b0, 0, 1'b1, 1'b1);
      for (int n = 0; n < 7; n++) begin
         step();
         chk($sformatf("seq_q[%0d]", n), 32'(bus0.Q), 32'(seq[n]));
      end
      chk("seq_wcnt", 32'(bus0.WCNT), 1);

      // Illegal then legal load.
      set_all(1'b1, 7, 1'b0, 1'b0);
      step();
      chk("ill_q", 32'(bus0.Q), 5);
      chk("ill_err", 32'(bus0.ERR), 1);
      set_all(1'b1, 2, 1'b0, 1'b0);
      step();
      chk("leg_q", 32'(bus0.Q), 2);
      chk("leg_err", 32'(bus0.ERR), 0);

      // Hold at zero: EN=1/BI=0, then EN=0/BI=1.
      set_all(1'b1, 0, 1'b0, 1'b0);
      step();
      set_all(1'b0, 0, 1'b1, 1'b0);
      for (int n = 0; n < 3; n++) step();
      set_all(1'b0, 0, 1'b0, 1'b1);
      for (int n = 0; n < 3; n++) step();
      chk("hold_q", 32'(bus0.Q), 0);
      chk("hold_zero", 32'(bus0.ZERO), 1);
      chk("hold_bo", 32'(bus0.BO), 0);

      // Load takes priority over a wrapping count.
      set_all(1'b1, 3, 1'b1, 1'b1);
      #1;
      chk("prio_bo", 32'(bus0.BO), 0);
      step();
      chk("prio_q", 32'(bus0.Q), 3);
      chk("prio_wcnt", 32'(bus0.WCNT), 1);

      // Cascade from 0/0 and WCNT saturation on the 2-bit stage.
      do_clear();
      set_all(1'b1, 0, 1'b0, 1'b0);
      step();
      set_all(1'b0, 0, 1'b1, 1'b1);
      step();
      chk("casc_q0", 32'(bus0.Q), 5);
      chk("casc_q1", 32'(bus1.Q), 5);
      chk("casc_wcnt0", 32'(bus0.WCNT), 1);
      chk("casc_wcnt1", 32'(bus1.WCNT), 1);
      for (int n = 0; n < 24; n++) step();
      chk("sat_wcnt2", 32'(bus2.WCNT), 3);
      for (int n = 0; n < 12; n++) step();
      chk("sat_hold_wcnt2", 32'(bus2.WCNT), 3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
